// File: rtl/argmin_pkg.sv
// Shared types for the arg-min/arg-max selector: candidate record and mode encoding.
package argmin_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_WIDTH = 12;
    localparam int DEF_IDX_W = $clog2(DEF_N);

    typedef enum logic {
        MODE_MIN = 1'b0,
        MODE_MAX = 1'b1
    } mode_e;

    // Default-sized candidate; instances with other sizes build a matching local type
    typedef struct packed {
        logic                 elig;
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_WIDTH-1:0] val;
    } cand_t;

endpackage

// File: rtl/argmin_node.sv
// Combinational 2-to-1 candidate select; a is the lower-index side and wins ties.
module argmin_node
    import argmin_pkg::*;
#(
    parameter type node_t = cand_t
) (
    input  mode_e mode,
    input  node_t a,
    input  node_t b,
    output node_t y
);

    logic b_better;

    always_comb begin
        b_better = (mode == MODE_MAX) ? (b.val > a.val) : (b.val < a.val);
        y = a;
        if (b.elig && (!a.elig || b_better)) begin
            y = b;
        end
    end

endmodule

// File: rtl/argmin_pipe.sv
// Pipelined arg-min/arg-max over N masked candidates, one tree level per register stage,
// with ready/valid flow control on both sides.
module argmin_pipe
    import argmin_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int WIDTH = 12,
    localparam int IDX_W = $clog2(N)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [N*WIDTH-1:0] vals_in,
    input  logic [N-1:0]       mask_in,
    input  logic               mode_max_in,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               found_out,
    output logic [IDX_W-1:0]   index_out,
    output logic [WIDTH-1:0]   value_out
);

    localparam int LEVELS = $clog2(N);
    localparam int PAD    = 1 << LEVELS;
    localparam int MODE_W = (LEVELS > 1) ? LEVELS - 1 : 1;

    typedef struct packed {
        logic             elig;
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] val;
    } node_cand_t;

    // Heap-ordered tree: node k combines children 2k and 2k+1, node 1 is the result
    node_cand_t  leaf   [PAD];
    node_cand_t  sel    [1:PAD-1];
    node_cand_t  tree_q [1:PAD-1];
    logic [LEVELS:1] vld_q;
    logic [MODE_W-1:0] mode_q;
    logic        stall;

    assign stall     = vld_q[LEVELS] && !ready_in;
    assign ready_out = !stall;

    for (genvar i = 0; i < PAD; i++) begin : g_leaf
        if (i < N) begin : g_real
            assign leaf[i] = '{elig: mask_in[i], idx: IDX_W'(i), val: vals_in[i*WIDTH +: WIDTH]};
        end else begin : g_pad
            assign leaf[i] = '{elig: 1'b0, idx: IDX_W'(i), val: {WIDTH{1'b0}}};
        end
    end

    // Each node reads the mode of the vector sitting one stage behind it
    for (genvar k = 1; k < PAD; k++) begin : g_node
        localparam int LVL = LEVELS - $clog2(k + 1) + 1;
        node_cand_t a;
        node_cand_t b;
        logic       m;

        if (2 * k >= PAD) begin : g_from_leaf
            assign a = leaf[2*k-PAD];
            assign b = leaf[2*k+1-PAD];
        end else begin : g_from_reg
            assign a = tree_q[2*k];
            assign b = tree_q[2*k+1];
        end

        if (LVL == 1) begin : g_mode_in
            assign m = mode_max_in;
        end else begin : g_mode_reg
            assign m = mode_q[LVL-2];
        end

        argmin_node #(
            .node_t (node_cand_t)
        ) u_node (
            .mode (mode_e'(m)),
            .a    (a),
            .b    (b),
            .y    (sel[k])
        );
    end

    // Whole pipe advances together; a stall freezes every stage including the outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int k = 1; k < PAD; k++) begin
                tree_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_q[1] <= valid_in;
            for (int l = 2; l <= LEVELS; l++) begin
                vld_q[l] <= vld_q[l-1];
            end
            if (LEVELS > 1) begin
                mode_q[0] <= mode_max_in;
            end
            for (int l = 1; l < LEVELS - 1; l++) begin
                mode_q[l] <= mode_q[l-1];
            end
            for (int k = 1; k < PAD; k++) begin
                tree_q[k] <= sel[k];
            end
        end
    end

    assign valid_out = vld_q[LEVELS];
    assign found_out = tree_q[1].elig;
    assign index_out = tree_q[1].idx;
    assign value_out = tree_q[1].val;

endmodule
